tx_frame_collector: RTL



---
 rtl/tx_frame_collector.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/tx_frame_collector.sv
`timescale 1ns/1ps
// Groups tx_en-high runs of a byte stream into frames, buffers each whole frame,
// then replays it on a valid/ready stream with length/XOR/error on the last beat.
module tx_frame_collector #(
  parameter int DATA_DEPTH = 32,
  parameter int DESC_DEPTH = 4,
  parameter int MAX_LEN    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [7:0]  out_len,
  output logic [7:0]  out_chk,
  output logic        out_err,
  output logic [15:0] frm_cnt,
  output logic [15:0] drop_cnt
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int QAW = $clog2(DESC_DEPTH);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} in_state_t;
  typedef enum logic {O_IDLE, O_DATA} out_state_t;
  typedef struct packed {
    logic [7:0] len;
    logic [7:0] chk;
    logic       err;
  } desc_t;

  // ---------------- byte FIFO (extra pointer bit distinguishes full/empty)
  logic [7:0] data_mem_q [DATA_DEPTH];
  logic [DAW:0] dwr_q, dwr_d, drd_q, drd_d;
  logic d_push, d_pop, d_full;

  assign d_full = (dwr_q[DAW] != drd_q[DAW]) && (dwr_q[DAW-1:0] == drd_q[DAW-1:0]);

  always_comb begin
    dwr_d = d_push ? dwr_q + (DAW+1)'(1) : dwr_q;
    drd_d = d_pop  ? drd_q + (DAW+1)'(1) : drd_q;
  end

  always_ff @(posedge clk) begin
    if (d_push) data_mem_q[dwr_q[DAW-1:0]] <= txd;
  end

  // ---------------- descriptor FIFO
  desc_t desc_mem_q [DESC_DEPTH];
  logic [QAW:0] qwr_q, qwr_d, qrd_q, qrd_d;
  logic q_push, q_pop, q_full, q_empty;
  desc_t q_wdata, q_rdata;

  assign q_full  = (qwr_q[QAW] != qrd_q[QAW]) && (qwr_q[QAW-1:0] == qrd_q[QAW-1:0]);
  assign q_empty = (qwr_q == qrd_q);
  assign q_rdata = desc_mem_q[qrd_q[QAW-1:0]];

  always_comb begin
    qwr_d = q_push ? qwr_q + (QAW+1)'(1) : qwr_q;
    qrd_d = q_pop  ? qrd_q + (QAW+1)'(1) : qrd_q;
  end

  always_ff @(posedge clk) begin
    if (q_push) desc_mem_q[qwr_q[QAW-1:0]] <= q_wdata;
  end

  // ---------------- input side
  in_state_t   in_state_q, in_state_d;
  logic [7:0]  len_q, len_d, chk_q, chk_d;
  logic        err_q, err_d;
  logic [15:0] frm_cnt_q, frm_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        take_byte;
  logic [7:0]  cur_len, cur_chk;
  logic        cur_err;

  always_comb begin
    in_state_d = in_state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    err_d      = err_q;
    frm_cnt_d  = frm_cnt_q;
    drop_cnt_d = drop_cnt_q;
    d_push     = 1'b0;
    q_push     = 1'b0;
    q_wdata    = '{len: len_q, chk: chk_q, err: err_q};
    take_byte  = 1'b0;
    cur_len    = len_q;
    cur_chk    = chk_q;
    cur_err    = err_q;
    case (in_state_q)
      SYNC: if (!tx_en) in_state_d = IDLE;
      IDLE: begin
        if (tx_en) begin
          if (q_full) begin
            in_state_d = DROP;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            in_state_d = RECV;
            cur_len    = 8'd0;
            cur_chk    = 8'd0;
            cur_err    = 1'b0;
            take_byte  = 1'b1;
          end
        end
      end
      RECV: begin
        if (tx_en) begin
          take_byte = 1'b1;
        end else begin
          q_push     = 1'b1;
          frm_cnt_d  = frm_cnt_q + 16'd1;
          in_state_d = IDLE;
        end
      end
      DROP: if (!tx_en) in_state_d = IDLE;
      default: in_state_d = SYNC;
    endcase
    // Bytes beyond capacity are counted as an error but never stored.
    if (take_byte) begin
      if (!d_full && (cur_len < MAX_LEN8)) begin
        d_push = 1'b1;
        len_d  = cur_len + 8'd1;
        chk_d  = cur_chk ^ txd;
        err_d  = cur_err;
      end else begin
        len_d  = cur_len;
        chk_d  = cur_chk;
        err_d  = 1'b1;
      end
    end
  end

  // ---------------- output side
  out_state_t o_state_q, o_state_d;
  logic [7:0] cnt_q, cnt_d, olen_q, olen_d, ochk_q, ochk_d;
  logic       oerr_q, oerr_d;

  always_comb begin
    o_state_d = o_state_q;
    cnt_d     = cnt_q;
    olen_d    = olen_q;
    ochk_d    = ochk_q;
    oerr_d    = oerr_q;
    q_pop     = 1'b0;
    d_pop     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'd0;
    out_len   = 8'd0;
    out_chk   = 8'd0;
    out_err   = 1'b0;
    case (o_state_q)
      O_IDLE: begin
        if (!q_empty) begin
          q_pop  = 1'b1;
          olen_d = q_rdata.len;
          ochk_d = q_rdata.chk;
          oerr_d = q_rdata.err;
          // Zero-length frames (all bytes discarded) are consumed silently.
          if (q_rdata.len != 8'd0) begin
            o_state_d = O_DATA;
            cnt_d     = q_rdata.len;
          end
        end
      end
      O_DATA: begin
        out_valid = 1'b1;
        out_data  = data_mem_q[drd_q[DAW-1:0]];
        out_last  = (cnt_q == 8'd1);
        if (out_last) begin
          out_len = olen_q;
          out_chk = ochk_q;
          out_err = oerr_q;
        end
        if (out_ready) begin
          d_pop = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (out_last) o_state_d = O_IDLE;
        end
      end
      default: o_state_d = O_IDLE;
    endcase
  end

  assign frm_cnt  = frm_cnt_q;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwr_q      <= '0;
      drd_q      <= '0;
      qwr_q      <= '0;
      qrd_q      <= '0;
      in_state_q <= SYNC;
      len_q      <= 8'd0;
      chk_q      <= 8'd0;
      err_q      <= 1'b0;
      frm_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
      o_state_q  <= O_IDLE;
      cnt_q      <= 8'd0;
      olen_q     <= 8'd0;
      ochk_q     <= 8'd0;
      oerr_q     <= 1'b0;
    end else begin
      dwr_q      <= dwr_d;
      drd_q      <= drd_d;
      qwr_q      <= qwr_d;
      qrd_q      <= qrd_d;
      in_state_q <= in_state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      frm_cnt_q  <= frm_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      o_state_q  <= o_state_d;
      cnt_q      <= cnt_d;
      olen_q     <= olen_d;
      ochk_q     <= ochk_d;
      oerr_q     <= oerr_d;
    end
  end

endmodule
